frame_parser: RTL and testbench
===============================

FRAME_PARSER -- requirements
Module: frame_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_DIM, default 16'd1024, largest legal width/height.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, idle limit inside a frame (used only under REQ-030).
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port s_data  in  8  byte from the UART receiver.
REQ-007 SHALL have ports s_vld in 1 / s_rdy out 1  upstream valid/ready handshake.
REQ-008 SHALL have port m_data  out  8  pixel toward data_path.
REQ-009 SHALL have ports m_vld out 1 / m_rdy in 1  downstream valid/ready handshake.
REQ-010 SHALL have ports m_sof, m_eol, m_eof  out  1 each  first pixel / last pixel of row / last pixel of frame, qualified by m_vld.
REQ-011 SHALL have ports width, height  out  16 each  latched header values.
REQ-012 SHALL have ports busy out 1 (frame in progress), hdr_err out 1 (one-cycle error pulse), frame_cnt out 16 (frames completed).

Function
REQ-013 SHALL implement states SYNC, W_LO, W_HI, H_LO, H_HI, PIX.
REQ-014 SHALL complete a transfer only when vld & rdy are both high in the same cycle.
REQ-015 SHALL hold s_rdy=1 in every state except PIX.
REQ-016 In SYNC, a byte equal to SYNC_BYTE SHALL advance to W_LO; any other byte SHALL be discarded with no state change.
REQ-017 SHALL assemble width as {W_HI,W_LO} and height as {H_HI,H_LO}, little-endian.
REQ-018 After H_HI, width or height equal to 0 or greater than MAX_DIM SHALL pulse hdr_err for one cycle and return to SYNC; otherwise the FSM SHALL enter PIX.
REQ-019 In PIX, s_rdy SHALL equal (~m_vld | m_rdy); each accepted byte SHALL load the output register, giving one-cycle latency.
REQ-020 m_data and the flags SHALL stay stable while m_vld=1 and m_rdy=0.
REQ-021 Column counter (16 bit) SHALL wrap to 0 at width-1 and increment the row counter; m_eol SHALL be 1 when col==width-1.
REQ-022 m_sof SHALL be 1 for col==0 && row==0; m_eof SHALL be 1 for col==width-1 && row==height-1.
REQ-023 On acceptance of the eof pixel, the FSM SHALL return to SYNC and frame_cnt SHALL increment, wrapping 16'hFFFF->0.
REQ-024 busy SHALL be 1 in states W_LO through PIX, and SHALL also be 1 while m_vld=1.
REQ-025 SHALL accept a SYNC_BYTE of the next frame on the cycle after eof acceptance; the pending eof output SHALL drain unaffected.
REQ-026 Bytes received during PIX SHALL be treated as pixels even if they equal SYNC_BYTE.

Reset
REQ-027 Asserting rst_n low SHALL, at any time including mid-frame, force state=SYNC and m_vld=0. All flags SHALL be 0, hdr_err=0, busy=0, counters=0, width=height=0, frame_cnt=0, and s_rdy=0.
REQ-028 After rst_n deasserts, s_rdy SHALL rise on the first clk edge.

Configuration
REQ-029 Macro FRAME_PARSER_TIMEOUT_EN SHALL gate the inactivity timeout.
REQ-030 When defined: in PIX, TIMEOUT_CYCLES consecutive cycles without an s_vld&s_rdy transfer SHALL abort the frame. The abort SHALL pulse hdr_err, drop a pending m_vld, and return to SYNC without incrementing frame_cnt. When undefined: no timer logic SHALL exist, and PIX SHALL wait indefinitely.

Verification
REQ-031 Send A5 02 00 02 00 11 22 33 44 with m_rdy=1. Expect 4 pixels 11,22,33,44 with sof on 11, eol on 22 and 44, eof on 44, and frame_cnt=1.
REQ-032 Send 00 FF A5 then header 01 00 01 00 and pixel 7E. Expect the first two bytes dropped and a single pixel 7E with sof=eol=eof=1.
REQ-033 Send header width=0. Expect a hdr_err pulse, no m_vld, and a return to SYNC; also send width=1025 and expect the same.
REQ-034 Use a 3x1 frame with m_rdy toggling 0/1 each cycle. Expect m_data stable while stalled, s_rdy=0 while m_vld&~m_rdy, and no loss or duplication.
REQ-035 Pulse rst_n low mid-PIX after 2 of 4 pixels. Expect outputs at their reset values, then the next full frame parses with frame_cnt=1.
REQ-036 With FRAME_PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=100, stop input after 1 pixel. Expect hdr_err at cycle 100 and frame_cnt unchanged.

Source files
------------

// File: rtl/frame_parser.sv
// frame_parser: sync/header/pixel stream parser; FRAME_PARSER_TIMEOUT_EN enables the in-frame idle abort.
module frame_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] MAX_DIM        = 16'd1024,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_vld,
  output logic        s_rdy,
  output logic [7:0]  m_data,
  output logic        m_vld,
  input  logic        m_rdy,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic [15:0] width,
  output logic [15:0] height,
  output logic        busy,
  output logic        hdr_err,
  output logic [15:0] frame_cnt
);
  typedef enum logic [2:0] {SYNC, W_LO, W_HI, H_LO, H_HI, PIX} state_t;
  state_t state, state_nxt;
  logic rdy_en, acc, last_col, last_row, hdr_bad, to_hit;
  logic [15:0] col, row, h_new;
  // rdy_en keeps s_rdy low through reset and raises it on the first edge after release
  assign s_rdy = rdy_en & ((state != PIX) | ~m_vld | m_rdy);
  assign acc = s_vld & s_rdy;
  assign last_col = col == width - 16'd1;
  assign last_row = row == height - 16'd1;
  assign h_new = {s_data, height[7:0]};
  assign hdr_bad = (width == 16'd0) | (width > MAX_DIM) | (h_new == 16'd0) | (h_new > MAX_DIM);
  assign busy = (state != SYNC) | m_vld;
`ifdef FRAME_PARSER_TIMEOUT_EN
  logic [31:0] idle;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle <= '0;
    else idle <= (state == PIX && !acc) ? idle + 32'd1 : '0;
  assign to_hit = (state == PIX) && !acc && (idle == 32'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SYNC;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (acc && s_data == SYNC_BYTE) state_nxt = W_LO;
      W_LO:    if (acc) state_nxt = W_HI;
      W_HI:    if (acc) state_nxt = H_LO;
      H_LO:    if (acc) state_nxt = H_HI;
      H_HI:    if (acc) state_nxt = hdr_bad ? SYNC : PIX;
      PIX:     if (to_hit || (acc && last_col && last_row)) state_nxt = SYNC;
      default: state_nxt = SYNC;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      hdr_err   <= 1'b0;
      width     <= '0;
      height    <= '0;
      col       <= '0;
      row       <= '0;
      m_data    <= '0;
      m_vld     <= 1'b0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
      m_eof     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rdy_en  <= 1'b1;
      hdr_err <= (state == H_HI && acc && hdr_bad) || to_hit;
      if (state == W_LO && acc) width[7:0] <= s_data;
      if (state == W_HI && acc) width[15:8] <= s_data;
      if (state == H_LO && acc) height[7:0] <= s_data;
      if (state == H_HI && acc) begin
        height[15:8] <= s_data;
        col          <= '0;
        row          <= '0;
      end
      if (state == PIX && acc) begin
        m_data <= s_data;
        m_sof  <= (col == 16'd0) && (row == 16'd0);
        m_eol  <= last_col;
        m_eof  <= last_col && last_row;
        col    <= last_col ? 16'd0 : col + 16'd1;
        row    <= last_col ? row + 16'd1 : row;
        if (last_col && last_row) frame_cnt <= frame_cnt + 16'd1;
      end
      m_vld <= to_hit ? 1'b0 : (state == PIX && acc) ? 1'b1 : m_rdy ? 1'b0 : m_vld;
    end
endmodule

// File: tb/tb_frame_parser.sv
// tb_frame_parser: randomized frames against a pixel-index reference model with a queued scoreboard.
module tb_frame_parser;
`ifdef FRAME_PARSER_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 50_000_000;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] s_data = '0, m_data;
  logic s_vld = 1'b0, s_rdy, m_vld, m_rdy = 1'b1, m_sof, m_eol, m_eof, busy, hdr_err;
  logic [15:0] width, height, frame_cnt;
  frame_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy), .m_sof(m_sof), .m_eol(m_eol),
    .m_eof(m_eof), .width(width), .height(height), .busy(busy), .hdr_err(hdr_err),
    .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [7:0] d; logic sof, eol, eof;} pix_t;
  pix_t exp_q[$];
  pix_t last_pix;
  logic [7:0] fixed_q[$];
  int compared = 0, mismatched = 0, err_seen = 0, err_exp = 0, fc_exp = 0, rdy_mode = 0;
  bit pix_phase = 0, gaps = 0, stalled = 0, prev_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  // monitor: pops the scoreboard on each downstream transfer and checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
      prev_err = 0;
    end else begin
      if (stalled) chk("stall_hold", {20'd0, m_vld, m_data, m_sof, m_eol, m_eof}, {20'd0, 1'b1, last_pix});
      if (hdr_err) begin
        err_seen++;
        chk("hdr_err_one_cycle", 32'(prev_err), 0);
      end
      prev_err = hdr_err;
      if (m_vld && m_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_pixel", {21'd0, m_data, m_sof, m_eol, m_eof}, 32'hFFFF_FFFF);
        else chk("pixel", {21'd0, m_data, m_sof, m_eol, m_eof}, {21'd0, exp_q.pop_front()});
      end
      if (pix_phase && m_vld && !m_rdy) chk("s_rdy_stall", 32'(s_rdy), 0);
      stalled = m_vld && !m_rdy;
      last_pix = {m_data, m_sof, m_eol, m_eof};
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    m_rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~m_rdy : 1'($urandom % 2);
  end
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (gaps && $urandom % 4 == 0) begin
      @(posedge clk);
      #1;
    end
    s_data = b;
    s_vld = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_rdy && n < 200);
    if (!s_rdy) chk("s_rdy_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_vld = 1'b0;
  endtask
  task automatic frame(input logic [15:0] w, input logic [15:0] h, input int junk);
    bit ok = w != 0 && h != 0 && w <= 16'd1024 && h <= 16'd1024;
    int n = int'(w) * int'(h);
    logic [7:0] p;
    for (int i = 0; i < junk; i++) begin
      p = 8'($urandom);
      send(p == 8'hA5 ? 8'h00 : p);
    end
    send(8'hA5);
    send(w[7:0]);
    send(w[15:8]);
    send(h[7:0]);
    send(h[15:8]);
    if (!ok) begin
      err_exp++;
      return;
    end
    pix_phase = 1;
    for (int i = 0; i < n; i++) begin
      p = fixed_q.size() > 0 ? fixed_q.pop_front() : 8'($urandom);
      exp_q.push_back({p, i == 0, i % int'(w) == int'(w) - 1, i == n - 1});
      send(p);
    end
    pix_phase = 0;
    fc_exp++;
  endtask
  task automatic settle(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), fc_exp);
    chk({tag, "_hdr_err_cnt"}, err_seen, err_exp);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_outs"}, {25'd0, m_vld, s_rdy, busy, hdr_err, m_sof, m_eol, m_eof}, 0);
    chk({tag, "_regs"}, {width, height}, 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s_rdy_before_edge", 32'(s_rdy), 0);
    @(posedge clk);
    #1;
    chk("s_rdy_after_edge", 32'(s_rdy), 1);
  endtask
  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    reset_vals("reset");
    release_rst();
    fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    frame(16'd2, 16'd2, 0);
    settle("basic");
    send(8'h00);
    send(8'hFF);
    fixed_q = '{8'h7E};
    frame(16'd1, 16'd1, 0);
    settle("junk");
    frame(16'd0, 16'd2, 0);
    frame(16'd1025, 16'd1, 0);
    frame(16'd2, 16'd0, 0);
    frame(16'd1, 16'd1025, 0);
    settle("bad_hdr");
    frame(16'd1024, 16'd1, 0);
    settle("max_dim");
    rdy_mode = 1;
    fixed_q = '{8'hA5, 8'hA5, 8'h5A};
    frame(16'd3, 16'd1, 0);
    settle("stall");
    rdy_mode = 0;
    send(8'hA5);
    send(8'd2);
    send(8'd0);
    send(8'd2);
    send(8'd0);
    pix_phase = 1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({8'(8'h60 + i), i == 0, i == 1, 1'b0});
      send(8'(8'h60 + i));
    end
    pix_phase = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    reset_vals("mid_reset");
    fc_exp = 0;
    release_rst();
    frame(16'd2, 16'd2, 0);
    settle("after_reset");
    gaps = 1;
    for (int k = 0; k < 10; k++) begin
      rdy_mode = $urandom % 3;
      frame(16'($urandom_range(0, 5)), 16'($urandom_range(1, 4)), $urandom_range(0, 3));
    end
    rdy_mode = 0;
    settle("random");
`ifdef FRAME_PARSER_TIMEOUT_EN
    gaps = 0;
    send(8'hA5);
    send(8'd4);
    send(8'd0);
    send(8'd1);
    send(8'd0);
    exp_q.push_back({8'h99, 1'b1, 1'b0, 1'b0});
    send(8'h99);
    repeat (90) @(posedge clk);
    #1;
    chk("timeout_early", err_seen, err_exp);
    repeat (20) @(posedge clk);
    #1;
    err_exp++;
    chk("timeout_busy", 32'(busy), 0);
    settle("timeout");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
